// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Also holds the bubble encoding used by the cpu pipeline registers.
package pipeline_ctrl_pkg;

  localparam int unsigned NUM_STAGES = 5;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned WAIT_W     = 4;

  localparam int unsigned ST_PC      = 0;
  localparam int unsigned ST_IF_ID   = 1;
  localparam int unsigned ST_ID_EXE  = 2;
  localparam int unsigned ST_EXE_MEM = 3;
  localparam int unsigned ST_MEM_WB  = 4;

  // A flushed pipeline register loads all-zero control and instruction fields.
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  localparam logic [NUM_STAGES-1:0] EN_ALL  = '1;
  localparam logic [NUM_STAGES-1:0] EN_NONE = '0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2
  } ctrl_state_e;

  // Registers younger than the resolve stage (IF_ID..br_stage) get a bubble on redirect.
  function automatic logic [NUM_STAGES-1:0] redirect_flush(input int unsigned br_stage);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int unsigned k = 1; k < NUM_STAGES; k++) m[k] = (k <= br_stage);
    return m;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                   cnt_d = '0;
    else if (en_i && ~&cnt_q)    cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Central stall/flush controller for the 5-stage core: load-use stalls,
// branch redirect flushes and multi-cycle data-memory waits, plus perf counters.
module pipeline_ctrl_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned BR_STAGE = 3,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  enable,
  input  logic [REG_W-1:0]      id_rs1,
  input  logic [REG_W-1:0]      id_rs2,
  input  logic                  id_uses_rs2,
  input  logic [REG_W-1:0]      exe_rd,
  input  logic                  exe_mem_read,
  input  logic                  redirect_valid,
  input  logic                  mem_req,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic                  pc_redirect,
  output logic [1:0]            ctrl_state,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      redirect_cnt
);

  localparam bit                    HAS_WAIT  = (MEM_LAT > 1);
  localparam logic [WAIT_W-1:0]     WAIT_INIT = WAIT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
  localparam logic [NUM_STAGES-1:0] BR_FLUSH  = redirect_flush(BR_STAGE);

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              issue;
  logic              load_use;
  logic              stall_inc;

  assign load_use = exe_mem_read && (exe_rd != '0) &&
                    ((exe_rd == id_rs1) || (id_uses_rs2 && (exe_rd == id_rs2)));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus the run-time hazard priority (redirect > load-use > advance).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stage_en    = EN_NONE;
    stage_flush = '0;
    pc_redirect = 1'b0;
    issue       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (HAS_WAIT && mem_req) begin
          state_d = S_MEM_WAIT;
          cnt_d   = WAIT_INIT;
        end else begin
          issue = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_W'(1);
        end else begin
          issue   = 1'b1;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (issue) begin
      if (redirect_valid) begin
        stage_en    = EN_ALL;
        stage_flush = BR_FLUSH;
        pc_redirect = 1'b1;
      end else if (load_use) begin
        stage_en                = EN_ALL;
        stage_en[ST_PC]         = 1'b0;
        stage_en[ST_IF_ID]      = 1'b0;
        stage_flush[ST_ID_EXE]  = 1'b1;
      end else begin
        stage_en = EN_ALL;
      end
    end
  end

  assign ctrl_state = state_q;
  assign stall_inc  = (state_q != S_IDLE) && !stage_en[ST_PC];

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .arst  (arst),
    .clr_i (1'b0),
    .en_i  (stall_inc),
    .cnt_o (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .arst  (arst),
    .clr_i (1'b0),
    .en_i  (pc_redirect),
    .cnt_o (redirect_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Scoreboard bench: three controller configurations share one stimulus stream and
// are checked every cycle against a per-configuration behavioural model.
module tb_pipeline_ctrl_unit;

  localparam int NDUT = 3;

  function automatic int cfg_br(input int d);
    return (d == 1) ? 2 : 3;
  endfunction
  function automatic int cfg_lat(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 3);
  endfunction
  function automatic int cfg_cw(input int d);
    return (d == 2) ? 4 : 32;
  endfunction

  typedef struct {
    logic [4:0]  en;
    logic [4:0]  flush;
    logic        redir;
    logic [1:0]  st;
    logic [31:0] stall;
    logic [31:0] rcnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       enable = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, exe_rd = '0;
  logic       id_uses_rs2 = 1'b0, exe_mem_read = 1'b0, redirect_valid = 1'b0, mem_req = 1'b0;

  logic [4:0]  en_w [NDUT];
  logic [4:0]  fl_w [NDUT];
  logic        rd_w [NDUT];
  logic [1:0]  st_w [NDUT];
  logic [31:0] sc_w [NDUT];
  logic [31:0] rc_w [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned CWG = cfg_cw(g);
    logic [CWG-1:0] sc, rc;
    pipeline_ctrl_unit #(
      .BR_STAGE(cfg_br(g)), .MEM_LAT(cfg_lat(g)), .CNT_W(CWG)
    ) u_dut (
      .clk            (clk),
      .arst           (arst),
      .enable         (enable),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_uses_rs2    (id_uses_rs2),
      .exe_rd         (exe_rd),
      .exe_mem_read   (exe_mem_read),
      .redirect_valid (redirect_valid),
      .mem_req        (mem_req),
      .stage_en       (en_w[g]),
      .stage_flush    (fl_w[g]),
      .pc_redirect    (rd_w[g]),
      .ctrl_state     (st_w[g]),
      .stall_cnt      (sc),
      .redirect_cnt   (rc)
    );
    assign sc_w[g] = 32'(sc);
    assign rc_w[g] = 32'(rc);
  end

  // Behavioural model: a memory access owns the pipeline for MEM_LAT-1 frozen
  // cycles, after which the held instruction proceeds through normal hazard rules.
  bit     m_idle   [NDUT];
  bit     m_access [NDUT];
  int     m_left   [NDUT];
  longint m_stall  [NDUT];
  longint m_red    [NDUT];
  exp_t   q [NDUT][$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic longint sat_max(input int d);
    return (64'd1 << cfg_cw(d)) - 1;
  endfunction

  task automatic model_step(input int d, output exp_t e);
    bit go;
    bit lu;
    e.en = '0; e.flush = '0; e.redir = 1'b0; e.st = 2'd0;
    e.stall = 32'(m_stall[d]); e.rcnt = 32'(m_red[d]);
    if (arst) begin
      e.stall = '0; e.rcnt = '0;
      m_idle[d] = 1; m_access[d] = 0; m_left[d] = 0; m_stall[d] = 0; m_red[d] = 0;
      return;
    end
    e.st = m_idle[d] ? 2'd0 : (m_access[d] ? 2'd2 : 2'd1);
    go = 0;
    if (!enable) begin
      m_idle[d] = 1; m_access[d] = 0; m_left[d] = 0;
    end else if (m_idle[d]) begin
      m_idle[d] = 0;
    end else if (m_access[d] && m_left[d] == 0) begin
      m_access[d] = 0; go = 1;
    end else if (m_access[d]) begin
      m_left[d]--;
    end else if (mem_req && cfg_lat(d) > 1) begin
      m_access[d] = 1; m_left[d] = cfg_lat(d) - 1;
      m_left[d]--;
    end else begin
      go = 1;
    end
    if (go) begin
      lu = exe_mem_read && exe_rd != 0 &&
           (exe_rd == id_rs1 || (id_uses_rs2 && exe_rd == id_rs2));
      if (redirect_valid) begin
        e.en = 5'b11111;
        e.flush = 5'(((1 << (cfg_br(d) + 1)) - 1) & ~1);
        e.redir = 1'b1;
        if (m_red[d] < sat_max(d)) m_red[d]++;
      end else if (lu) begin
        e.en = 5'b11100; e.flush = 5'b00100;
      end else begin
        e.en = 5'b11111;
      end
    end
    if (e.st != 2'd0 && !e.en[0] && m_stall[d] < sat_max(d)) m_stall[d]++;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_exp();
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      model_step(d, e);
      q[d].push_back(e);
    end
  endtask

  task automatic nop();
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_uses_rs2 = 1'b0;
    exe_rd = 5'd0; exe_mem_read = 1'b0; redirect_valid = 1'b0; mem_req = 1'b0;
  endtask

  task automatic run_nops(input int n);
    for (int i = 0; i < n; i++) begin
      edge_wait(); nop(); push_exp();
    end
  endtask

  // Monitor: compares the DUT outputs presented in each cycle with the queued expectation.
  exp_t x;
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (q[d].size() > 0) begin
        x = q[d].pop_front();
        total++;
        if ({en_w[d], fl_w[d], rd_w[d], st_w[d]} !== {x.en, x.flush, x.redir, x.st}) begin
          bad++;
          $display("FAIL ctrl dut%0d cyc%0d en/flush/redir/state got %b_%b_%b_%0d want %b_%b_%b_%0d",
                   d, cyc, en_w[d], fl_w[d], rd_w[d], st_w[d], x.en, x.flush, x.redir, x.st);
        end
        total++;
        if (sc_w[d] !== x.stall) begin
          bad++;
          $display("FAIL stall_cnt dut%0d cyc%0d got %0d want %0d", d, cyc, sc_w[d], x.stall);
        end
        total++;
        if (rc_w[d] !== x.rcnt) begin
          bad++;
          $display("FAIL redirect_cnt dut%0d cyc%0d got %0d want %0d", d, cyc, rc_w[d], x.rcnt);
        end
      end
    end
  end

  initial begin
    // reset, then IDLE -> RUN
    for (int i = 0; i < 2; i++) begin
      edge_wait(); arst = 1'b1; enable = 1'b0; nop(); push_exp();
    end
    edge_wait(); arst = 1'b0; enable = 1'b1; nop(); push_exp();
    run_nops(2);

    // load-use via rs1, via rs2, rs2 match ignored when rs2 unused, and rd=x0
    edge_wait(); nop(); exe_mem_read = 1'b1; exe_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd1;
    id_uses_rs2 = 1'b1; push_exp();
    run_nops(1);
    edge_wait(); nop(); exe_mem_read = 1'b1; exe_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
    id_uses_rs2 = 1'b1; push_exp();
    edge_wait(); nop(); exe_mem_read = 1'b1; exe_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
    id_uses_rs2 = 1'b0; push_exp();
    edge_wait(); nop(); exe_mem_read = 1'b1; exe_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_uses_rs2 = 1'b1; push_exp();
    run_nops(1);

    // redirect pulse
    edge_wait(); nop(); redirect_valid = 1'b1; push_exp();
    run_nops(1);

    // memory access held four cycles
    for (int i = 0; i < 4; i++) begin
      edge_wait(); nop(); mem_req = 1'b1; push_exp();
    end
    run_nops(2);

    // redirect arriving during a memory wait, held by the frozen pipeline
    edge_wait(); nop(); mem_req = 1'b1; push_exp();
    for (int i = 0; i < 3; i++) begin
      edge_wait(); nop(); redirect_valid = 1'b1; push_exp();
    end
    run_nops(1);

    // load-use and redirect together: redirect wins
    edge_wait(); nop(); redirect_valid = 1'b1; exe_mem_read = 1'b1; exe_rd = 5'd4;
    id_rs1 = 5'd4; push_exp();
    run_nops(1);

    // reset in the middle of a memory wait
    edge_wait(); nop(); mem_req = 1'b1; push_exp();
    edge_wait(); nop(); arst = 1'b1; push_exp();
    edge_wait(); nop(); arst = 1'b0; enable = 1'b1; push_exp();
    run_nops(2);

    // enable drop mid-run
    edge_wait(); nop(); enable = 1'b0; push_exp();
    edge_wait(); nop(); enable = 1'b1; push_exp();
    run_nops(1);

    // long run of stalls to saturate the narrow counter
    for (int i = 0; i < 24; i++) begin
      edge_wait(); nop(); mem_req = 1'b1; push_exp();
    end

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      edge_wait();
      arst           = ($urandom_range(0, 299) == 0);
      enable         = ($urandom_range(0, 19) != 0);
      id_rs1         = 5'($urandom_range(0, 3));
      id_rs2         = 5'($urandom_range(0, 3));
      id_uses_rs2    = 1'($urandom_range(0, 1));
      exe_rd         = 5'($urandom_range(0, 3));
      exe_mem_read   = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 4) == 0);
      mem_req        = ($urandom_range(0, 3) == 0);
      push_exp();
    end
    edge_wait(); arst = 1'b0; enable = 1'b1; nop();

    @(negedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      total++;
      if (q[d].size() != 0) begin
        bad++;
        $display("FAIL drain dut%0d got %0d pending want 0", d, q[d].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
